// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the architectural PC, runs the imem
// request/ack handshake, presents instructions to the decoder and picks next_pc.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_accept,
    input  logic        br_taken,
    input  logic [15:0] br_imm16,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        addr_misalign,
    output logic [31:0] inst_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   w_inst_nxt;
    logic [XLEN-1:0]   r_inst_pc;
    logic [XLEN-1:0]   w_inst_pc_nxt;
    logic [XLEN-1:0]   r_count;
    logic [XLEN-1:0]   w_count_nxt;
    logic              r_mis;
    logic              w_mis_nxt;
    logic              r_req;
    logic              r_valid;

    logic [XLEN-1:0]   w_seq;
    logic [XLEN-1:0]   w_br_off;
    logic [XLEN-1:0]   w_target;
    logic              w_tgt_mis;

    // Redirect target selection, highest priority first.
    assign w_seq    = r_inst_pc + XLEN'(4);
    assign w_br_off = {{14{br_imm16[15]}}, br_imm16, 2'b00};

    always_comb begin
        w_target = w_seq;
        if (exc) begin
            w_target = EXC_VECTOR;
        end else if (eret) begin
            w_target = epc;
        end else if (jr) begin
            w_target = jr_target;
        end else if (jmp) begin
            w_target = {w_seq[31:28], jmp_index, 2'b00};
        end else if (br_taken) begin
            w_target = w_seq + w_br_off;
        end
    end

    assign w_tgt_mis = |w_target[1:0];

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_count_nxt   = r_count;
        w_mis_nxt     = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_inst_nxt    = imem_rdata;
                    w_inst_pc_nxt = r_pc;
                    w_state_nxt   = ST_VALID;
                end
            end
            ST_VALID: begin
                if (dec_accept) begin
                    w_pc_nxt    = {w_target[31:2], 2'b00};
                    w_mis_nxt   = w_tgt_mis;
                    w_count_nxt = r_count + XLEN'(1);
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // Handshake flags are registered from the next state so no output is combinational.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RESET;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_count   <= '0;
            r_mis     <= 1'b0;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_count   <= w_count_nxt;
            r_mis     <= w_mis_nxt;
            r_req     <= (w_state_nxt == ST_FETCH);
            r_valid   <= (w_state_nxt == ST_VALID);
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_pc;
    assign inst_valid    = r_valid;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign inst_count    = r_count;
    assign addr_misalign = r_mis;

endmodule
